pattern_loader: RTL and testbench

PATTERN_LOADER -- requirements
Module: pattern_loader

---
 rtl/pattern_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_pattern_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_loader.sv
// Frame-based serial loader: streams handshaked words MSB first on sin/sclk under ssel.
// Optional readback of sout into rdata/rvalid is enabled by defining LOADER_READBACK_EN.
module pattern_loader #(
   parameter int unsigned buffer_size  = 32,
   parameter int unsigned buffer_width = 6,
   parameter int unsigned CLK_DIV      = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [2:0]                      addr,
   input  logic [$clog2(buffer_size)-1:0]  nwords,
   input  logic [buffer_width-1:0]         wdata,
   input  logic                            wvalid,
   output logic                            wready,
   output logic                            busy,
   output logic                            done,
   output logic                            sclk,
   output logic                            sin,
   output logic                            ssel,
   output logic [2:0]                      saddr,
   input  logic                            sout,
   output logic [buffer_width-1:0]         rdata,
   output logic                            rvalid
);

   localparam int unsigned NW = $clog2(buffer_size);
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BW = (buffer_width > 1) ? $clog2(buffer_width) : 1;
   localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BitTop  = BW'(buffer_width - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StShift, StStall, StHold} state_e;

   state_e                  state_q, state_d;
   logic [DW-1:0]           div_q, div_d;
   logic                    sclk_q, sclk_d;
   logic                    sin_q, sin_d;
   logic                    ssel_q, ssel_d;
   logic [2:0]              saddr_q, saddr_d;
   logic                    done_q, done_d;
   logic [NW-1:0]           nwords_q, nwords_d;
   logic [NW-1:0]           word_idx_q, word_idx_d;
   logic [NW:0]             acc_cnt_q, acc_cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [buffer_width-1:0] shreg_q, shreg_d;
   logic [buffer_width-1:0] buf_q, buf_d;
   logic                    buf_valid_q, buf_valid_d;

   logic                    wready_int, accept, word_avail, div_end, load;
   logic [buffer_width-1:0] next_word, shifted;

   // One-word buffer in front of the shifter; accepts until the frame's word count is reached.
   assign wready_int = ((state_q == StSetup) || (state_q == StShift) || (state_q == StStall)) &&
                       !buf_valid_q && (acc_cnt_q <= {1'b0, nwords_q});
   assign accept     = wvalid && wready_int;
   assign word_avail = buf_valid_q || accept;
   assign next_word  = buf_valid_q ? buf_q : wdata;
   assign div_end    = (div_q == DivLast);
   assign shifted    = shreg_q << 1;

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      sclk_d      = sclk_q;
      sin_d       = sin_q;
      ssel_d      = ssel_q;
      saddr_d     = saddr_q;
      done_d      = 1'b0;
      nwords_d    = nwords_q;
      word_idx_d  = word_idx_q;
      acc_cnt_d   = acc_cnt_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      load        = 1'b0;

      if (accept) begin
         buf_d       = wdata;
         buf_valid_d = 1'b1;
         acc_cnt_d   = acc_cnt_q + (NW+1)'(1);
      end

      unique case (state_q)
         StIdle: begin
            // done_q blocks a start arriving in the frame-end cycle
            if (start && !done_q) begin
               state_d    = StSetup;
               ssel_d     = 1'b1;
               saddr_d    = addr;
               nwords_d   = nwords;
               word_idx_d = '0;
               acc_cnt_d  = '0;
               div_d      = '0;
            end
         end
         StSetup: begin
            if (!div_end) begin
               div_d = div_q + DW'(1);
            end else if (word_avail) begin
               load    = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            if (!div_end) begin
               div_d = div_q + DW'(1);
            end else begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q != '0) begin
                     shreg_d = shifted;
                     sin_d   = shifted[buffer_width-1];
                     bit_d   = bit_q - BW'(1);
                  end else if (word_idx_q == nwords_q) begin
                     state_d = StHold;
                     sin_d   = 1'b0;
                  end else begin
                     word_idx_d = word_idx_q + NW'(1);
                     if (word_avail) begin
                        load = 1'b1;
                     end else begin
                        state_d = StStall;
                     end
                  end
               end
            end
         end
         StStall: begin
            if (word_avail) begin
               load    = 1'b1;
               state_d = StShift;
            end
         end
         StHold: begin
            if (div_end) begin
               state_d = StIdle;
               ssel_d  = 1'b0;
               done_d  = 1'b1;
               div_d   = '0;
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // A load restarts the bit timer so the first rise is a full low phase away.
      if (load) begin
         shreg_d     = next_word;
         sin_d       = next_word[buffer_width-1];
         bit_d       = BitTop;
         buf_valid_d = 1'b0;
         div_d       = '0;
         sclk_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         div_q       <= '0;
         sclk_q      <= 1'b0;
         sin_q       <= 1'b0;
         ssel_q      <= 1'b0;
         saddr_q     <= '0;
         done_q      <= 1'b0;
         nwords_q    <= '0;
         word_idx_q  <= '0;
         acc_cnt_q   <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         sclk_q      <= sclk_d;
         sin_q       <= sin_d;
         ssel_q      <= ssel_d;
         saddr_q     <= saddr_d;
         done_q      <= done_d;
         nwords_q    <= nwords_d;
         word_idx_q  <= word_idx_d;
         acc_cnt_q   <= acc_cnt_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         buf_q       <= buf_d;
         buf_valid_q <= buf_valid_d;
      end
   end

   assign wready = wready_int;
   assign busy   = (state_q != StIdle);
   assign done   = done_q;
   assign sclk   = sclk_q;
   assign sin    = sin_q;
   assign ssel   = ssel_q;
   assign saddr  = saddr_q;

`ifdef LOADER_READBACK_EN
   logic [buffer_width-1:0] rb_sh_q, rb_next, rdata_q;
   logic                    rvalid_q, sclk_rise;

   assign sclk_rise = (state_q == StShift) && div_end && !sclk_q;
   assign rb_next   = (rb_sh_q << 1) | buffer_width'(sout);

   always_ff @(posedge clk) begin
      if (rst) begin
         rb_sh_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         if (sclk_rise) begin
            rb_sh_q <= rb_next;
            if (bit_q == '0) begin
               rdata_q  <= rb_next;
               rvalid_q <= 1'b1;
            end
         end
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
`else
   logic unused_sout;
   assign unused_sout = sout;
   assign rdata       = '0;
   assign rvalid      = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_loader.sv
// Scoreboard bench for pattern_loader: random frames, expected bits/frames queued by the driver,
// checked by an independent monitor sampling on the falling clk edge.
module tb_pattern_loader;

   localparam int W  = 6;
   localparam int NW = 5;
   localparam int CD = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    addr = '0;
   logic [NW-1:0] nwords = '0;
   logic [W-1:0]  wdata = '0;
   logic          wvalid = 1'b0;
   logic          wready, busy, done, sclk, sin, ssel, sout, rvalid;
   logic [2:0]    saddr;
   logic [W-1:0]  rdata;
   logic [W-1:0]  lb = 6'h2A;

   assign sout = lb[W-1];

   pattern_loader #(.buffer_size(32), .buffer_width(W), .CLK_DIV(CD)) dut (
      .clk(clk), .rst(rst), .start(start), .addr(addr), .nwords(nwords), .wdata(wdata),
      .wvalid(wvalid), .wready(wready), .busy(busy), .done(done), .sclk(sclk), .sin(sin),
      .ssel(ssel), .saddr(saddr), .sout(sout), .rdata(rdata), .rvalid(rvalid)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit exp_bits[$];
   int exp_len[$];
   logic [2:0] exp_addr[$];
   int rise_cnt = 0;
   int done_cnt = 0;
   int xfer_cnt = 0;
   int cyc = 0;
   int last_rise = 0;
   bit chk_interval = 1'b0;
   bit rb_bad = 1'b0;
   bit rb_first = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitor: pops expected bits on each sclk rise and expected frame lengths on each done.
   initial begin
      bit   b;
      bit   prev_sclk = 1'b0;
      bit   prev_sin  = 1'b0;
      int   l;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_sclk = 1'b0;
            prev_sin  = 1'b0;
            continue;
         end
         if (wvalid && wready) xfer_cnt++;
         if (sclk) check("sin_stable_while_sclk_high", sin, prev_sin);
         if (sclk && !prev_sclk) begin
            rise_cnt++;
            if (exp_bits.size() == 0) fail("unexpected_sclk_rise");
            else begin
               b = exp_bits.pop_front();
               check("sin_bit", sin, b);
            end
            if (exp_addr.size() > 0) check("saddr", saddr, exp_addr[0]);
            check("ssel_busy_at_rise", {ssel, busy}, 2'b11);
            if (chk_interval && rise_cnt > 1) check("rise_interval", cyc - last_rise, 2 * CD);
            last_rise = cyc;
            lb = {lb[W-2:0], sin};
         end
`ifdef LOADER_READBACK_EN
         if (rvalid && !rb_first) begin
            check("rdata_first_readback", rdata, 6'h2A);
            rb_first = 1'b1;
         end
`else
         if (rvalid || rdata != '0) rb_bad = 1'b1;
`endif
         if (done) begin
            if (exp_len.size() == 0) fail("unexpected_done");
            else begin
               l = exp_len.pop_front();
               void'(exp_addr.pop_front());
               check("frame_rise_count", rise_cnt, l);
               check("bits_left_at_done", exp_bits.size(), 0);
            end
            check("readback_idle_default", rb_bad, 1'b0);
            rise_cnt = 0;
            done_cnt++;
         end
         prev_sclk = sclk;
         prev_sin  = sin;
      end
   end

   task automatic run_frame(input logic [2:0] a, input int n, input int gap_idx,
                            input int gap_len, input bit strict, input bit poke);
      logic [W-1:0] w;
      int bound;
      int d0;
      chk_interval = strict;
      exp_addr.push_back(a);
      exp_len.push_back((n + 1) * W);
      xfer_cnt = 0;
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; addr = a; nwords = NW'(n);
      @(posedge clk); #1;
      start = 1'b0; addr = 3'($urandom); nwords = NW'($urandom);
      for (int i = 0; i <= n; i++) begin
         if (i == gap_idx) begin
            wvalid = 1'b0;
            repeat (gap_len) @(posedge clk);
            #1;
            if (gap_len >= 40) check("stall_sclk_ssel_wready", {sclk, ssel, wready}, 3'b011);
         end
         if (i == 1 && poke) begin
            start = 1'b1; addr = ~a;
            @(posedge clk); #1;
            start = 1'b0;
         end
         w = W'($urandom);
         if (i == 0 && a == 3'd5 && n == 0) w = 6'b101101;
         for (int k = W - 1; k >= 0; k--) exp_bits.push_back(w[k]);
         wvalid = 1'b1; wdata = w;
         bound = 0;
         while (1) begin
            @(negedge clk);
            if (wready) break;
            bound++;
            if (bound > 3000) begin fail("wready_timeout"); break; end
         end
         @(posedge clk); #1;
      end
      // Keep offering surplus words; none may be taken.
      wvalid = 1'b1; wdata = W'($urandom);
      bound = 0;
      while (done_cnt == d0) begin
         @(negedge clk); #1;
         bound++;
         if (bound > 6000) begin fail("done_timeout"); break; end
      end
      wvalid = 1'b0;
      check("word_transfers", xfer_cnt, n + 1);
      if (poke) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         check("start_in_done_cycle_ignored", busy, 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int bound;
      int n;
      int g;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sclk", sclk, 0);
      check("rst_sin", sin, 0);
      check("rst_ssel", ssel, 0);
      check("rst_saddr", saddr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wready", wready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;

      run_frame(3'd5, 0, -1, 0, 1'b1, 1'b0);
      run_frame(3'd2, 31, -1, 0, 1'b1, 1'b1);
      run_frame(3'd6, 1, 1, 40, 1'b0, 1'b0);

      // Reset after the third sclk rise of a frame.
      exp_addr.push_back(3'd3);
      exp_len.push_back(3 * W);
      @(posedge clk); #1;
      start = 1'b1; addr = 3'd3; nwords = NW'(2);
      @(posedge clk); #1;
      start = 1'b0;
      wvalid = 1'b1; wdata = W'($urandom);
      for (int k = W - 1; k >= 0; k--) exp_bits.push_back(wdata[k]);
      bound = 0;
      while (rise_cnt < 3) begin
         @(posedge clk);
         if (wready) begin #1; wvalid = 1'b0; end
         bound++;
         if (bound > 500) begin fail("rise3_timeout"); break; end
      end
      #1;
      rst = 1'b1; wvalid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midreset_ssel_sclk_busy", {ssel, sclk, busy}, 3'b000);
      exp_bits.delete(); exp_len.delete(); exp_addr.delete();
      rise_cnt = 0;
      repeat (12) @(posedge clk);
      #1;
      check("no_rise_after_reset", rise_cnt, 0);
      check("no_done_after_reset", done, 0);

      run_frame(3'd3, 2, -1, 0, 1'b1, 1'b0);
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(0, 4);
         g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n)) : -1;
         run_frame(3'($urandom), n, g, $urandom_range(1, 45), 1'b0, f[0]);
      end

      check("expected_frames_drained", exp_len.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
